// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit unsigned adder built from two half_adder
// cells plus an OR (full adder) and a carry flip-flop. One bit pair per clock,
// LSB first, under a start/done handshake.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request, sampled only in IDLE
//   a, b  - WIDTH-bit operands, captured on the accepting edge
//   sub   - subtract select (only when SERIAL_ADDER_SUB_EN is defined)
//   busy  - high while the operation is running
//   done  - one-cycle pulse, sum/cout valid
//   sum   - WIDTH-bit result (doubles as the result shift register)
//   cout  - final carry (no-borrow flag when subtracting)
//
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub port; a - b via ~b
// and carry-in of 1).

// Half adder cell: combinational sum and carry of two bits.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s_c,
  output logic c_c
);
  assign s_c = x ^ y;
  assign c_c = x & y;
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic s1_c, c1_c, s2_c, c2_c, carry_next_c;

  // Full adder on the current LSBs and the running carry.
  half_adder u_ha1 (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .s_c (s1_c),
    .c_c (c1_c)
  );

  half_adder u_ha2 (
    .x   (s1_c),
    .y   (carry),
    .s_c (s2_c),
    .c_c (c2_c)
  );

  assign carry_next_c = c1_c | c2_c;

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
`ifdef SERIAL_ADDER_SUB_EN
            // Two's complement subtract: invert b and inject a carry-in.
            b_sr  <= sub ? ~b : b;
            carry <= sub;
`else
            b_sr  <= b;
            carry <= 1'b0;
`endif
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          // New sum bit enters at the MSB; after WIDTH shifts sum is aligned.
          sum   <= {s2_c, sum[WIDTH-1:1]};
          carry <= carry_next_c;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout  <= carry_next_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder: WIDTH=8 handshake/timing/boundary cases
// and an exhaustive WIDTH=2 instance.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] a, b, sum;
  logic       busy, done, cout;

  logic       start2;
  logic [1:0] a2, b2, sum2;
  logic       busy2, done2, cout2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .a     (a2),
    .b     (b2),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (1'b0),
`endif
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation; exp = {cout, sum}. Leaves the DUT back in IDLE
  // so the next call accepts at the earliest legal edge.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                      input logic [8:0] exp, input string tag);
    a = av; b = bv; sub = sv; start = 1'b1;
    step();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    chk({tag, " busy@accept"}, 32'(busy), 32'd1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk({tag, " busy/done in run"}, 32'({busy, done}), 32'b10);
    end
    step();
    chk({tag, " done"}, 32'({busy, done}), 32'b01);
    chk({tag, " result"}, 32'({cout, sum}), 32'(exp));
    step();
    chk({tag, " done drop"}, 32'(done), 32'd0);
    chk({tag, " result hold"}, 32'({cout, sum}), 32'(exp));
  endtask

  task automatic run2(input logic [1:0] av, input logic [1:0] bv, input logic [2:0] exp);
    a2 = av; b2 = bv; start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();
    chk("w2 early done", 32'(done2), 32'd0);
    step();
    chk("w2 done", 32'(done2), 32'd1);
    chk("w2 result", 32'({cout2, sum2}), 32'(exp));
    step();
  endtask

  initial begin
    int dones;
    logic [8:0] at_done;
    logic [7:0] ra, rb;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    step(); step();
    chk("reset outputs", 32'({busy, done, cout, sum}), 32'd0);
    chk("reset outputs w2", 32'({busy2, done2, cout2, sum2}), 32'd0);
    rst = 1'b0;
    step();
    chk("idle no done", 32'({busy, done}), 32'd0);

    run8(8'd3,   8'd5,   1'b0, 9'd8,   "3+5");
    run8(8'd255, 8'd1,   1'b0, 9'h100, "255+1");
    run8(8'd200, 8'd100, 1'b0, 9'h12C, "200+100");
    run8(8'd0,   8'd0,   1'b0, 9'd0,   "0+0");
    run8(8'd255, 8'd255, 1'b0, 9'h1FE, "255+255");

    // start pulses while busy must be ignored.
    a = 8'd10; b = 8'd20; start = 1'b1;
    step();
    dones = 0; at_done = '0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 2 || c == 5) begin
        start = 1'b1; a = 8'd1; b = 8'd1;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) begin
        dones++;
        at_done = {cout, sum};
      end
    end
    chk("ignore start dones", 32'(dones), 32'd1);
    chk("ignore start result", 32'(at_done), 32'd30);
    chk("ignore start no restart", 32'(busy), 32'd0);

    // Asynchronous reset mid-operation.
    a = 8'hAA; b = 8'h55; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    chk("midop reset outputs", 32'({busy, done, cout, sum}), 32'd0);
    step();
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (done) dones++;
    end
    chk("no done after abort", 32'(dones), 32'd0);
    run8(8'd100, 8'd27, 1'b0, 9'd127, "post-reset 100+27");

`ifdef SERIAL_ADDER_SUB_EN
    run8(8'd5, 8'd3, 1'b1, 9'h102, "5-3");
    run8(8'd3, 8'd5, 1'b1, 9'h0FE, "3-5");
    run8(8'd3, 8'd5, 1'b0, 9'd8,   "3+5 sub=0");
`endif

    // Random WIDTH=8 vectors against {cout,sum} = a + b.
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run8(ra, rb, 1'b0, 9'(ra) + 9'(rb), "rand8");
    end

    // Exhaustive WIDTH=2.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        run2(2'(i), 2'(j), 3'(i + j));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
